jtframe_bank_slots: RTL and testbench



---
 rtl/jtframe_bank_slots_pkg.sv | 9 +
 rtl/jtframe_slot_cache.sv | 50 +++++
 rtl/jtframe_bank_slots.sv | 216 +++++++++++++++++++++
 tb/tb_jtframe_bank_slots.sv | 428 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtframe_bank_slots_pkg.sv
// Shared types and constants for the four-slot SDRAM bank arbiter.
package jtframe_bank_slots_pkg;

    localparam int unsigned SLOTS  = 4;
    localparam int unsigned TOUT_W = 8;

    typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

endpackage

// File: rtl/jtframe_slot_cache.sv
// One-word read cache for a ROM slot: tag, data and valid with hit compare.
module jtframe_slot_cache #(
    parameter int unsigned AW = 16
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [AW-1:0] addr_i,
    input  logic          cs_i,
    input  logic          fill_i,
    input  logic [AW-1:0] fill_addr_i,
    input  logic [15:0]   fill_data_i,
    input  logic          flush_i,
    output logic          ok_o,
    output logic [15:0]   dout_o
);

    logic [AW-1:0] tag_q, tag_d;
    logic [15:0]   data_q, data_d;
    logic          valid_q, valid_d;

    // Flush wins over a fill landing in the same cycle.
    always_comb begin
        tag_d   = tag_q;
        data_d  = data_q;
        valid_d = valid_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (fill_i) begin
            tag_d   = fill_addr_i;
            data_d  = fill_data_i;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tag_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            tag_q   <= tag_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign ok_o   = cs_i & valid_q & (addr_i == tag_q);
    assign dout_o = data_q;

endmodule

// File: rtl/jtframe_bank_slots.sv
// Four cached ROM slots sharing one SDRAM bank read port, round-robin with a
// watchdog that abandons transactions whose data never arrives.
module jtframe_bank_slots
    import jtframe_bank_slots_pkg::*;
#(
    parameter int unsigned       SDRAMW  = 22,
    parameter int unsigned       AW0     = 16,
    parameter int unsigned       AW1     = 16,
    parameter int unsigned       AW2     = 16,
    parameter int unsigned       AW3     = 16,
    parameter logic [SDRAMW-1:0] OFFSET0 = '0,
    parameter logic [SDRAMW-1:0] OFFSET1 = '0,
    parameter logic [SDRAMW-1:0] OFFSET2 = '0,
    parameter logic [SDRAMW-1:0] OFFSET3 = '0,
    parameter int unsigned       TOUT    = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              downloading,
    input  logic [SLOTS-1:0]  slot_cs,
    input  logic [AW0-1:0]    slot0_addr,
    input  logic [AW1-1:0]    slot1_addr,
    input  logic [AW2-1:0]    slot2_addr,
    input  logic [AW3-1:0]    slot3_addr,
    output logic [SLOTS-1:0]  slot_ok,
    output logic [15:0]       slot0_dout,
    output logic [15:0]       slot1_dout,
    output logic [15:0]       slot2_dout,
    output logic [15:0]       slot3_dout,
    output logic [SDRAMW-1:0] sdram_addr,
    output logic              sdram_rd,
    input  logic              sdram_ack,
    input  logic              sdram_dst,
    input  logic              sdram_rdy,
    input  logic [15:0]       sdram_din,
    output logic              timeout_err
);

    state_e            state_q, state_d;
    logic [1:0]        sel_q, sel_d;
    logic [1:0]        ptr_q, ptr_d;
    logic [SDRAMW-1:0] addr_q, addr_d;
    logic [SDRAMW-1:0] sdram_addr_q, sdram_addr_d;
    logic              rd_q, rd_d;
    logic [TOUT_W-1:0] wd_q, wd_d;
    logic              err_q, err_d;

    logic [SDRAMW-1:0] ext  [SLOTS];
    logic [SDRAMW-1:0] offs [SLOTS];
    logic [SLOTS-1:0]  pend;
    logic [SLOTS-1:0]  fill;
    logic              done;
    logic              found;
    logic [1:0]        pick;

    assign ext[0]  = SDRAMW'(slot0_addr);
    assign ext[1]  = SDRAMW'(slot1_addr);
    assign ext[2]  = SDRAMW'(slot2_addr);
    assign ext[3]  = SDRAMW'(slot3_addr);
    assign offs[0] = OFFSET0;
    assign offs[1] = OFFSET1;
    assign offs[2] = OFFSET2;
    assign offs[3] = OFFSET3;

    assign pend = slot_cs & ~slot_ok;

    // First pending slot at or after the pointer, wrapping 3 -> 0.
    always_comb begin
        found = 1'b0;
        pick  = ptr_q;
        for (int unsigned i = 0; i < SLOTS; i++) begin
            if (!found && pend[ptr_q + 2'(i)]) begin
                found = 1'b1;
                pick  = ptr_q + 2'(i);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            sel_q        <= '0;
            ptr_q        <= '0;
            addr_q       <= '0;
            sdram_addr_q <= '0;
            rd_q         <= 1'b0;
            wd_q         <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            ptr_q        <= ptr_d;
            addr_q       <= addr_d;
            sdram_addr_q <= sdram_addr_d;
            rd_q         <= rd_d;
            wd_q         <= wd_d;
            err_q        <= err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        ptr_d        = ptr_q;
        addr_d       = addr_q;
        sdram_addr_d = sdram_addr_q;
        rd_d         = rd_q;
        wd_d         = wd_q;
        err_d        = err_q;
        if (downloading) begin
            state_d = StIdle;
            rd_d    = 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (found) begin
                        sel_d        = pick;
                        addr_d       = ext[pick];
                        sdram_addr_d = offs[pick] + ext[pick];
                        rd_d         = 1'b1;
                        state_d      = StReq;
                    end
                end
                StReq: begin
                    if (sdram_ack) begin
                        rd_d    = 1'b0;
                        wd_d    = '0;
                        state_d = sdram_rdy ? StIdle : StWait;
                    end
                end
                StWait: begin
                    if (sdram_rdy) begin
                        state_d = StIdle;
                    end else if (wd_q == TOUT_W'(TOUT)) begin
                        err_d   = 1'b1;
                        state_d = StIdle;
                    end else begin
                        wd_d = wd_q + TOUT_W'(1);
                    end
                end
                default: state_d = StIdle;
            endcase
            if (done) begin
                ptr_d = sel_q + 2'd1;
            end
        end
    end

    always_comb begin
        done = !downloading && sdram_rdy &&
               ((state_q == StReq && sdram_ack) || state_q == StWait);
        fill        = '0;
        fill[sel_q] = done;
    end

    assign sdram_addr  = sdram_addr_q;
    assign sdram_rd    = rd_q;
    assign timeout_err = err_q;

    // Data-start strobe and the latched bits above each slot's width are not needed.
    logic unused_sig;
    assign unused_sig = ^{sdram_dst, addr_q};

    jtframe_slot_cache #(.AW(AW0)) u_cache0 (
        .clk_i       (clk),
        .rst_i       (rst),
        .addr_i      (slot0_addr),
        .cs_i        (slot_cs[0]),
        .fill_i      (fill[0]),
        .fill_addr_i (addr_q[AW0-1:0]),
        .fill_data_i (sdram_din),
        .flush_i     (downloading),
        .ok_o        (slot_ok[0]),
        .dout_o      (slot0_dout)
    );

    jtframe_slot_cache #(.AW(AW1)) u_cache1 (
        .clk_i       (clk),
        .rst_i       (rst),
        .addr_i      (slot1_addr),
        .cs_i        (slot_cs[1]),
        .fill_i      (fill[1]),
        .fill_addr_i (addr_q[AW1-1:0]),
        .fill_data_i (sdram_din),
        .flush_i     (downloading),
        .ok_o        (slot_ok[1]),
        .dout_o      (slot1_dout)
    );

    jtframe_slot_cache #(.AW(AW2)) u_cache2 (
        .clk_i       (clk),
        .rst_i       (rst),
        .addr_i      (slot2_addr),
        .cs_i        (slot_cs[2]),
        .fill_i      (fill[2]),
        .fill_addr_i (addr_q[AW2-1:0]),
        .fill_data_i (sdram_din),
        .flush_i     (downloading),
        .ok_o        (slot_ok[2]),
        .dout_o      (slot2_dout)
    );

    jtframe_slot_cache #(.AW(AW3)) u_cache3 (
        .clk_i       (clk),
        .rst_i       (rst),
        .addr_i      (slot3_addr),
        .cs_i        (slot_cs[3]),
        .fill_i      (fill[3]),
        .fill_addr_i (addr_q[AW3-1:0]),
        .fill_data_i (sdram_din),
        .flush_i     (downloading),
        .ok_o        (slot_ok[3]),
        .dout_o      (slot3_dout)
    );

endmodule

// File: tb/tb_jtframe_bank_slots.sv
// Self-checking bench for jtframe_bank_slots with an SDRAM responder and a
// slot-level cache/round-robin reference model.
module tb_jtframe_bank_slots;

    localparam int unsigned TOUT = 255;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        downloading = 1'b0;
    logic [3:0]  slot_cs = '0;
    logic [15:0] addr_v [4];
    logic [15:0] a0, a1, a2, a3;
    logic [3:0]  slot_ok;
    logic [15:0] d0, d1, d2, d3;
    logic [21:0] sdram_addr;
    logic        sdram_rd;
    logic        sdram_ack = 1'b0;
    logic        sdram_dst = 1'b0;
    logic        sdram_rdy = 1'b0;
    logic [15:0] sdram_din = '0;
    logic        timeout_err;

    int checks = 0;
    int failures = 0;

    // Reference model: per-slot cache contents and round-robin pointer.
    bit          m_valid [4];
    logic [15:0] m_tag   [4];
    logic [15:0] m_data  [4];
    int          m_ptr;

    assign a0 = addr_v[0];
    assign a1 = addr_v[1];
    assign a2 = addr_v[2];
    assign a3 = addr_v[3];

    always #5 clk = ~clk;

    jtframe_bank_slots #(
        .SDRAMW  (22),
        .OFFSET0 (22'h10_0000),
        .OFFSET1 (22'h20_0000),
        .OFFSET2 (22'h30_0000),
        .OFFSET3 (22'h3F_FFF0),
        .TOUT    (TOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .downloading (downloading),
        .slot_cs     (slot_cs),
        .slot0_addr  (a0),
        .slot1_addr  (a1),
        .slot2_addr  (a2),
        .slot3_addr  (a3),
        .slot_ok     (slot_ok),
        .slot0_dout  (d0),
        .slot1_dout  (d1),
        .slot2_dout  (d2),
        .slot3_dout  (d3),
        .sdram_addr  (sdram_addr),
        .sdram_rd    (sdram_rd),
        .sdram_ack   (sdram_ack),
        .sdram_dst   (sdram_dst),
        .sdram_rdy   (sdram_rdy),
        .sdram_din   (sdram_din),
        .timeout_err (timeout_err)
    );

    function automatic logic [21:0] off(int n);
        case (n)
            0: return 22'h10_0000;
            1: return 22'h20_0000;
            2: return 22'h30_0000;
            default: return 22'h3F_FFF0;
        endcase
    endfunction

    function automatic logic [21:0] exp_addr(int n);
        return off(n) + {6'd0, addr_v[n]};
    endfunction

    function automatic logic [15:0] get_dout(int n);
        case (n)
            0: return d0;
            1: return d1;
            2: return d2;
            default: return d3;
        endcase
    endfunction

    function automatic bit m_hit(int n);
        return slot_cs[n] && m_valid[n] && (m_tag[n] == addr_v[n]);
    endfunction

    function automatic logic [3:0] m_ok();
        logic [3:0] r;
        for (int n = 0; n < 4; n++) r[n] = m_hit(n);
        return r;
    endfunction

    function automatic int model_pick();
        for (int i = 0; i < 4; i++) begin
            int n;
            n = (m_ptr + i) % 4;
            if (slot_cs[n] && !m_hit(n)) return n;
        end
        return -1;
    endfunction

    task automatic model_fill(input int n, input logic [15:0] d);
        m_valid[n] = 1'b1;
        m_tag[n]   = addr_v[n];
        m_data[n]  = d;
        m_ptr      = (n + 1) % 4;
    endtask

    task automatic model_clear(input bit full);
        for (int n = 0; n < 4; n++) begin
            m_valid[n] = 1'b0;
            if (full) begin
                m_tag[n]  = '0;
                m_data[n] = '0;
            end
        end
        if (full) m_ptr = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rd(output bit got);
        int n;
        n = 0;
        while (!sdram_rd && n < 50) begin
            step();
            n++;
        end
        got = sdram_rd;
    endtask

    // SDRAM responder: ack after ack_dly cycles, rdy rdy_dly cycles after ack.
    task automatic serve(input int ack_dly, input int rdy_dly, input logic [15:0] din,
                         output logic [21:0] a, output bit got);
        wait_rd(got);
        a = sdram_addr;
        if (!got) return;
        repeat (ack_dly) step();
        sdram_ack = 1'b1;
        if (rdy_dly == 0) begin
            sdram_rdy = 1'b1;
            sdram_din = din;
        end
        step();
        sdram_ack = 1'b0;
        sdram_rdy = 1'b0;
        if (rdy_dly > 0) begin
            repeat (rdy_dly - 1) step();
            sdram_rdy = 1'b1;
            sdram_din = din;
            step();
            sdram_rdy = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        model_clear(1'b1);
    endtask

    task automatic test_reset();
        for (int n = 0; n < 4; n++) addr_v[n] = '0;
        repeat (2) step();
        rst = 1'b0;
        model_clear(1'b1);
        checks++; if (slot_ok !== 4'b0) begin failures++;
            $display("FAIL reset_ok got %b want 0000", slot_ok); end
        checks++; if (sdram_rd !== 1'b0) begin failures++;
            $display("FAIL reset_rd got %b want 0", sdram_rd); end
        checks++; if (sdram_addr !== 22'd0) begin failures++;
            $display("FAIL reset_addr got %h want 0", sdram_addr); end
        checks++; if (timeout_err !== 1'b0) begin failures++;
            $display("FAIL reset_err got %b want 0", timeout_err); end
        checks++; if ({d0, d1, d2, d3} !== 64'd0) begin failures++;
            $display("FAIL reset_dout got %h want 0", {d0, d1, d2, d3}); end
    endtask

    task automatic test_single_miss();
        bit got;
        slot_cs   = 4'b0001;
        addr_v[0] = 16'h0010;
        wait_rd(got);
        checks++; if (got !== 1'b1) begin failures++;
            $display("FAIL miss_rd got %b want 1", got); end
        checks++; if (sdram_addr !== 22'h10_0010) begin failures++;
            $display("FAIL miss_addr got %h want 100010", sdram_addr); end
        repeat (2) begin
            step();
            checks++; if (sdram_rd !== 1'b1) begin failures++;
                $display("FAIL miss_rd_hold got %b want 1", sdram_rd); end
        end
        sdram_ack = 1'b1;
        step();
        sdram_ack = 1'b0;
        checks++; if (sdram_rd !== 1'b0) begin failures++;
            $display("FAIL miss_rd_drop got %b want 0", sdram_rd); end
        repeat (3) begin
            step();
            checks++; if (slot_ok[0] !== 1'b0) begin failures++;
                $display("FAIL miss_ok_early got %b want 0", slot_ok[0]); end
        end
        sdram_rdy = 1'b1;
        sdram_din = 16'hBEEF;
        step();
        sdram_rdy = 1'b0;
        model_fill(0, 16'hBEEF);
        checks++; if (slot_ok[0] !== 1'b1) begin failures++;
            $display("FAIL miss_ok got %b want 1", slot_ok[0]); end
        checks++; if (d0 !== 16'hBEEF) begin failures++;
            $display("FAIL miss_dout got %h want beef", d0); end
    endtask

    task automatic test_hit();
        addr_v[0] = 16'h0011;
        #1;
        checks++; if (slot_ok[0] !== 1'b0) begin failures++;
            $display("FAIL hit_addr_change got %b want 0", slot_ok[0]); end
        addr_v[0] = 16'h0010;
        #1;
        checks++; if (slot_ok[0] !== 1'b1) begin failures++;
            $display("FAIL hit_ok got %b want 1", slot_ok[0]); end
        repeat (3) begin
            step();
            checks++; if (sdram_rd !== 1'b0) begin failures++;
                $display("FAIL hit_no_req got %b want 0", sdram_rd); end
        end
    endtask

    task automatic test_round_robin();
        bit          got;
        logic [21:0] a;
        logic [15:0] d;
        int          order [6] = '{0, 1, 2, 3, 0, 2};
        do_reset();
        slot_cs = 4'b1111;
        for (int n = 0; n < 4; n++) addr_v[n] = 16'h0020 + 16'(n);
        for (int k = 0; k < 6; k++) begin
            if (k == 4) begin
                addr_v[0] = 16'h0030;
                addr_v[2] = 16'h0032;
            end
            d = 16'($urandom);
            serve($urandom_range(0, 2), $urandom_range(0, 3), d, a, got);
            checks++; if (got !== 1'b1 || a !== exp_addr(order[k])) begin failures++;
                $display("FAIL rr_order step %0d got %b/%h want 1/%h", k, got, a,
                         exp_addr(order[k])); end
            model_fill(order[k], d);
            if (k == 3) begin
                checks++; if (slot_ok !== 4'b1111) begin failures++;
                    $display("FAIL rr_all_ok got %b want 1111", slot_ok); end
            end
        end
        checks++; if (slot_ok !== m_ok()) begin failures++;
            $display("FAIL rr_final_ok got %b want %b", slot_ok, m_ok()); end
    endtask

    task automatic test_download();
        bit          got;
        logic [21:0] a;
        logic [15:0] d;
        int          n;
        downloading = 1'b1;
        step();
        downloading = 1'b0;
        model_clear(1'b0);
        checks++; if (slot_ok !== 4'b0000) begin failures++;
            $display("FAIL dl_flush got %b want 0000", slot_ok); end
        for (int k = 0; k < 4; k++) begin
            n = model_pick();
            d = 16'($urandom);
            serve(1, 2, d, a, got);
            checks++; if (got !== 1'b1 || a !== exp_addr(n)) begin failures++;
                $display("FAIL dl_refill %0d got %b/%h want 1/%h", k, got, a, exp_addr(n)); end
            model_fill(n, d);
        end
        checks++; if (slot_ok !== 4'b1111) begin failures++;
            $display("FAIL dl_refill_ok got %b want 1111", slot_ok); end
        // Held download blocks a pending miss.
        addr_v[1]   = 16'h0041;
        downloading = 1'b1;
        model_clear(1'b0);
        repeat (3) begin
            step();
            checks++; if (sdram_rd !== 1'b0) begin failures++;
                $display("FAIL dl_block got %b want 0", sdram_rd); end
        end
        downloading = 1'b0;
        // Download mid-request abandons it.
        wait_rd(got);
        checks++; if (got !== 1'b1) begin failures++;
            $display("FAIL dl_rereq got %b want 1", got); end
        downloading = 1'b1;
        step();
        downloading = 1'b0;
        checks++; if (sdram_rd !== 1'b0) begin failures++;
            $display("FAIL dl_abandon got %b want 0", sdram_rd); end
        for (int k = 0; k < 4; k++) begin
            n = model_pick();
            if (n >= 0) begin
                d = 16'($urandom);
                serve(0, 1, d, a, got);
                checks++; if (got !== 1'b1 || a !== exp_addr(n)) begin failures++;
                    $display("FAIL dl_after %0d got %b/%h want 1/%h", k, got, a, exp_addr(n)); end
                model_fill(n, d);
            end
        end
        checks++; if (slot_ok !== 4'b1111) begin failures++;
            $display("FAIL dl_after_ok got %b want 1111", slot_ok); end
    endtask

    task automatic test_timeout();
        bit          got;
        logic [21:0] a;
        slot_cs   = 4'b0010;
        addr_v[1] = 16'h0077;
        wait_rd(got);
        checks++; if (got !== 1'b1 || sdram_addr !== exp_addr(1)) begin failures++;
            $display("FAIL to_req got %b/%h want 1/%h", got, sdram_addr, exp_addr(1)); end
        sdram_ack = 1'b1;
        step();
        sdram_ack = 1'b0;
        repeat (TOUT) step();
        checks++; if (timeout_err !== 1'b0) begin failures++;
            $display("FAIL to_early got %b want 0", timeout_err); end
        step();
        checks++; if (timeout_err !== 1'b1) begin failures++;
            $display("FAIL to_fire got %b want 1", timeout_err); end
        checks++; if (slot_ok[1] !== 1'b0) begin failures++;
            $display("FAIL to_no_fill got %b want 0", slot_ok[1]); end
        step();
        checks++; if (sdram_rd !== 1'b1 || sdram_addr !== exp_addr(1)) begin failures++;
            $display("FAIL to_rereq got %b/%h want 1/%h", sdram_rd, sdram_addr, exp_addr(1)); end
        serve(0, 1, 16'h1234, a, got);
        model_fill(1, 16'h1234);
        checks++; if (slot_ok[1] !== 1'b1 || d1 !== 16'h1234) begin failures++;
            $display("FAIL to_complete got %b/%h want 1/1234", slot_ok[1], d1); end
        checks++; if (timeout_err !== 1'b1) begin failures++;
            $display("FAIL to_sticky got %b want 1", timeout_err); end
    endtask

    task automatic test_reset_mid();
        bit          got;
        logic [21:0] a;
        slot_cs   = 4'b1111;
        addr_v[0] = 16'h0040;
        wait_rd(got);
        checks++; if (got !== 1'b1) begin failures++;
            $display("FAIL rm_req got %b want 1", got); end
        #2 rst = 1'b1;
        #1;
        checks++; if (sdram_rd !== 1'b0 || slot_ok !== 4'b0000 || timeout_err !== 1'b0) begin
            failures++;
            $display("FAIL rm_async got rd=%b ok=%b err=%b want 0/0000/0", sdram_rd, slot_ok,
                     timeout_err); end
        @(negedge clk);
        rst = 1'b0;
        model_clear(1'b1);
        serve(1, 1, 16'hCAFE, a, got);
        checks++; if (got !== 1'b1 || a !== exp_addr(0)) begin failures++;
            $display("FAIL rm_first got %b/%h want 1/%h", got, a, exp_addr(0)); end
        model_fill(0, 16'hCAFE);
    endtask

    task automatic test_random();
        bit          got;
        logic [21:0] a;
        logic [15:0] d;
        int          n;
        for (int it = 0; it < 30; it++) begin
            slot_cs = 4'($urandom_range(1, 15));
            for (int s = 0; s < 4; s++) addr_v[s] = 16'h000E + 16'($urandom_range(0, 3));
            for (int k = 0; k < 5; k++) begin
                n = model_pick();
                if (n >= 0) begin
                    d = 16'($urandom);
                    serve($urandom_range(0, 3), $urandom_range(0, 5), d, a, got);
                    checks++; if (got !== 1'b1 || a !== exp_addr(n)) begin failures++;
                        $display("FAIL rand_req it %0d got %b/%h want 1/%h", it, got, a,
                                 exp_addr(n)); end
                    model_fill(n, d);
                end
            end
            repeat (2) step();
            checks++; if (sdram_rd !== 1'b0) begin failures++;
                $display("FAIL rand_idle it %0d got %b want 0", it, sdram_rd); end
            checks++; if (slot_ok !== m_ok()) begin failures++;
                $display("FAIL rand_ok it %0d got %b want %b", it, slot_ok, m_ok()); end
            for (int s = 0; s < 4; s++) begin
                checks++; if (get_dout(s) !== m_data[s]) begin failures++;
                    $display("FAIL rand_dout it %0d slot %0d got %h want %h", it, s,
                             get_dout(s), m_data[s]); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_miss();
        test_hit();
        test_round_robin();
        test_download();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500_000;
        $display("FAIL global_timeout got running want finished");
        $fatal(1, "bench time limit");
    end

endmodule
